// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the dispatcher and its operand resolver.
// Widths here are the defaults; module parameters may override them.
package dispatcher_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ROB_ID_W_DEF = 4;
    localparam int OPENUM_W_DEF = 6;
    localparam int REG_W_DEF    = 5;

    typedef logic [DATA_W_DEF-1:0]   DATA_TYPE;
    typedef logic [DATA_W_DEF-1:0]   ADDR_TYPE;
    typedef logic [ROB_ID_W_DEF-1:0] ROB_ID_TYPE;
    typedef logic [OPENUM_W_DEF-1:0] OPENUM_TYPE;

    localparam ROB_ID_TYPE ZERO_ROB   = '0;
    localparam DATA_TYPE   ZERO_WORD  = '0;
    localparam OPENUM_TYPE OPENUM_NOP = '0;
    localparam logic       FALSE      = 1'b0;
    localparam logic       TRUE       = 1'b1;

    typedef enum logic {
        DSP_EMPTY = 1'b0,
        DSP_HELD  = 1'b1
    } dsp_state_e;

endpackage

// File: rtl/dispatcher_operand_resolve.sv
// Per-operand source selection at capture time:
// unused -> regfile -> RS CDB -> LS CDB -> ROB ready value -> keep tag.
module dsp_operand_resolve #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4
) (
    input  logic                unused_i,
    input  logic [ROB_ID_W-1:0] q_reg_i,
    input  logic [DATA_W-1:0]   v_reg_i,
    input  logic                rs_cdb_valid_i,
    input  logic [ROB_ID_W-1:0] rs_cdb_id_i,
    input  logic [DATA_W-1:0]   rs_cdb_result_i,
    input  logic                ls_cdb_valid_i,
    input  logic [ROB_ID_W-1:0] ls_cdb_id_i,
    input  logic [DATA_W-1:0]   ls_cdb_result_i,
    input  logic                rob_ready_i,
    input  logic [DATA_W-1:0]   rob_value_i,
    output logic [ROB_ID_W-1:0] q_o,
    output logic [DATA_W-1:0]   v_o
);

    // priority mux; a zero tag means the regfile value is already final
    always_comb begin
        q_o = '0;
        v_o = '0;
        if (!unused_i) begin
            if (q_reg_i == '0) begin
                v_o = v_reg_i;
            end else if (rs_cdb_valid_i && rs_cdb_id_i == q_reg_i) begin
                v_o = rs_cdb_result_i;
            end else if (ls_cdb_valid_i && ls_cdb_id_i == q_reg_i) begin
                v_o = ls_cdb_result_i;
            end else if (rob_ready_i) begin
                v_o = rob_value_i;
            end else begin
                q_o = q_reg_i;
            end
        end
    end

endmodule

// File: rtl/dispatcher.sv
// Dispatcher: one-entry skid between decoder and RS/LSB/ROB, with renaming.
// Optional DSP_STALL_CNT_EN adds stall_cnt_o (cycles held without dispatch).
module dispatcher
    import dispatcher_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int OPENUM_W = OPENUM_W_DEF,
    parameter int REG_W    = REG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                valid_from_dcd,
    input  logic [OPENUM_W-1:0] openum_from_dcd,
    input  logic [DATA_W-1:0]   pc_from_dcd,
    input  logic [DATA_W-1:0]   imm_from_dcd,
    input  logic [REG_W-1:0]    rd_from_dcd,
    input  logic [REG_W-1:0]    rs1_from_dcd,
    input  logic [REG_W-1:0]    rs2_from_dcd,
    input  logic                use_rs2_from_dcd,
    input  logic                is_ls_from_dcd,
    output logic                stall_to_dcd,
    output logic [REG_W-1:0]    rs1_to_reg,
    output logic [REG_W-1:0]    rs2_to_reg,
    input  logic [ROB_ID_W-1:0] Q1_from_reg,
    input  logic [ROB_ID_W-1:0] Q2_from_reg,
    input  logic [DATA_W-1:0]   V1_from_reg,
    input  logic [DATA_W-1:0]   V2_from_reg,
    output logic [ROB_ID_W-1:0] Q1_to_rob,
    output logic [ROB_ID_W-1:0] Q2_to_rob,
    input  logic                ready1_from_rob,
    input  logic                ready2_from_rob,
    input  logic [DATA_W-1:0]   value1_from_rob,
    input  logic [DATA_W-1:0]   value2_from_rob,
    input  logic [ROB_ID_W-1:0] free_id_from_rob,
    input  logic                full_from_rob,
    output logic                ena_to_rob,
    output logic [REG_W-1:0]    rd_to_rob,
    output logic [OPENUM_W-1:0] openum_to_rob,
    output logic [DATA_W-1:0]   pc_to_rob,
    output logic                ena_to_reg,
    output logic [REG_W-1:0]    rd_to_reg,
    output logic [ROB_ID_W-1:0] rob_id_to_reg,
    input  logic                full_from_rs,
    input  logic                full_from_lsb,
    output logic                ena_to_rs,
    output logic                ena_to_lsb,
    output logic [OPENUM_W-1:0] openum_to_rs_lsb,
    output logic [DATA_W-1:0]   V1_to_rs_lsb,
    output logic [DATA_W-1:0]   V2_to_rs_lsb,
    output logic [ROB_ID_W-1:0] Q1_to_rs_lsb,
    output logic [ROB_ID_W-1:0] Q2_to_rs_lsb,
    output logic [DATA_W-1:0]   pc_to_rs_lsb,
    output logic [DATA_W-1:0]   imm_to_rs_lsb,
    output logic [ROB_ID_W-1:0] rob_id_to_rs_lsb,
    input  logic                valid_from_rs_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb,
    input  logic [DATA_W-1:0]   result_from_rs_cdb,
    input  logic                valid_from_ls_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
    input  logic [DATA_W-1:0]   result_from_ls_cdb,
    input  logic                rollback_flag_from_rob
`ifdef DSP_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    dsp_state_e state_q, state_d;

    logic [OPENUM_W-1:0] op_q, op_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic                is_ls_q, is_ls_d;
    logic [ROB_ID_W-1:0] q1_q, q1_d;
    logic [ROB_ID_W-1:0] q2_q, q2_d;
    logic [DATA_W-1:0]   v1_q, v1_d;
    logic [DATA_W-1:0]   v2_q, v2_d;

    logic                ena_rs_q, ena_rs_d;
    logic                ena_lsb_q, ena_lsb_d;
    logic                ena_rob_q, ena_rob_d;
    logic                ena_reg_q, ena_reg_d;
    logic [OPENUM_W-1:0] out_op_q, out_op_d;
    logic [DATA_W-1:0]   out_pc_q, out_pc_d;
    logic [DATA_W-1:0]   out_imm_q, out_imm_d;
    logic [REG_W-1:0]    out_rd_q, out_rd_d;
    logic [ROB_ID_W-1:0] out_q1_q, out_q1_d;
    logic [ROB_ID_W-1:0] out_q2_q, out_q2_d;
    logic [DATA_W-1:0]   out_v1_q, out_v1_d;
    logic [DATA_W-1:0]   out_v2_q, out_v2_d;
    logic [ROB_ID_W-1:0] out_tag_q, out_tag_d;

    logic [ROB_ID_W-1:0] cap_q1, cap_q2;
    logic [DATA_W-1:0]   cap_v1, cap_v2;
    logic [ROB_ID_W-1:0] snp_q1, snp_q2;
    logic [DATA_W-1:0]   snp_v1, snp_v2;

    logic held;
    logic full_sel;
    logic dispatch;
    logic capture;

    assign rs1_to_reg = rs1_from_dcd;
    assign rs2_to_reg = rs2_from_dcd;
    assign Q1_to_rob  = Q1_from_reg;
    assign Q2_to_rob  = Q2_from_reg;

    dsp_operand_resolve #(
        .DATA_W  (DATA_W),
        .ROB_ID_W(ROB_ID_W)
    ) u_res1 (
        .unused_i       (rs1_from_dcd == '0),
        .q_reg_i        (Q1_from_reg),
        .v_reg_i        (V1_from_reg),
        .rs_cdb_valid_i (valid_from_rs_cdb),
        .rs_cdb_id_i    (rob_id_from_rs_cdb),
        .rs_cdb_result_i(result_from_rs_cdb),
        .ls_cdb_valid_i (valid_from_ls_cdb),
        .ls_cdb_id_i    (rob_id_from_ls_cdb),
        .ls_cdb_result_i(result_from_ls_cdb),
        .rob_ready_i    (ready1_from_rob),
        .rob_value_i    (value1_from_rob),
        .q_o            (cap_q1),
        .v_o            (cap_v1)
    );

    dsp_operand_resolve #(
        .DATA_W  (DATA_W),
        .ROB_ID_W(ROB_ID_W)
    ) u_res2 (
        .unused_i       ((rs2_from_dcd == '0) || !use_rs2_from_dcd),
        .q_reg_i        (Q2_from_reg),
        .v_reg_i        (V2_from_reg),
        .rs_cdb_valid_i (valid_from_rs_cdb),
        .rs_cdb_id_i    (rob_id_from_rs_cdb),
        .rs_cdb_result_i(result_from_rs_cdb),
        .ls_cdb_valid_i (valid_from_ls_cdb),
        .ls_cdb_id_i    (rob_id_from_ls_cdb),
        .ls_cdb_result_i(result_from_ls_cdb),
        .rob_ready_i    (ready2_from_rob),
        .rob_value_i    (value2_from_rob),
        .q_o            (cap_q2),
        .v_o            (cap_v2)
    );

    // held operands pick up CDB broadcasts; RS CDB wins over LS CDB
    always_comb begin
        snp_q1 = q1_q;
        snp_v1 = v1_q;
        snp_q2 = q2_q;
        snp_v2 = v2_q;
        if (q1_q != '0) begin
            if (valid_from_rs_cdb && rob_id_from_rs_cdb == q1_q) begin
                snp_q1 = '0;
                snp_v1 = result_from_rs_cdb;
            end else if (valid_from_ls_cdb && rob_id_from_ls_cdb == q1_q) begin
                snp_q1 = '0;
                snp_v1 = result_from_ls_cdb;
            end
        end
        if (q2_q != '0) begin
            if (valid_from_rs_cdb && rob_id_from_rs_cdb == q2_q) begin
                snp_q2 = '0;
                snp_v2 = result_from_rs_cdb;
            end else if (valid_from_ls_cdb && rob_id_from_ls_cdb == q2_q) begin
                snp_q2 = '0;
                snp_v2 = result_from_ls_cdb;
            end
        end
    end

    // handshake: dispatch frees the skid, so a new capture may share the edge
    always_comb begin
        held         = (state_q == DSP_HELD);
        full_sel     = is_ls_q ? full_from_lsb : full_from_rs;
        dispatch     = rdy && !rollback_flag_from_rob && held
                       && !full_from_rob && !full_sel;
        stall_to_dcd = held && !dispatch;
        capture      = rdy && !rollback_flag_from_rob
                       && valid_from_dcd && !stall_to_dcd;
    end

    // next state, skid contents and registered dispatch outputs
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        is_ls_d   = is_ls_q;
        q1_d      = q1_q;
        v1_d      = v1_q;
        q2_d      = q2_q;
        v2_d      = v2_q;
        ena_rs_d  = FALSE;
        ena_lsb_d = FALSE;
        ena_rob_d = FALSE;
        ena_reg_d = FALSE;
        out_op_d  = out_op_q;
        out_pc_d  = out_pc_q;
        out_imm_d = out_imm_q;
        out_rd_d  = out_rd_q;
        out_q1_d  = out_q1_q;
        out_q2_d  = out_q2_q;
        out_v1_d  = out_v1_q;
        out_v2_d  = out_v2_q;
        out_tag_d = out_tag_q;
        if (rollback_flag_from_rob) begin
            state_d = DSP_EMPTY;
        end else if (rdy) begin
            q1_d = snp_q1;
            v1_d = snp_v1;
            q2_d = snp_q2;
            v2_d = snp_v2;
            if (dispatch) begin
                state_d   = DSP_EMPTY;
                ena_rs_d  = !is_ls_q;
                ena_lsb_d = is_ls_q;
                ena_rob_d = TRUE;
                ena_reg_d = (rd_q != '0);
                out_op_d  = op_q;
                out_pc_d  = pc_q;
                out_imm_d = imm_q;
                out_rd_d  = rd_q;
                out_q1_d  = snp_q1;
                out_v1_d  = snp_v1;
                out_q2_d  = snp_q2;
                out_v2_d  = snp_v2;
                out_tag_d = free_id_from_rob;
            end
            if (capture) begin
                state_d = DSP_HELD;
                op_d    = openum_from_dcd;
                pc_d    = pc_from_dcd;
                imm_d   = imm_from_dcd;
                rd_d    = rd_from_dcd;
                is_ls_d = is_ls_from_dcd;
                q1_d    = cap_q1;
                v1_d    = cap_v1;
                q2_d    = cap_q2;
                v2_d    = cap_v2;
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DSP_EMPTY;
            op_q      <= OPENUM_W'(OPENUM_NOP);
            pc_q      <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            is_ls_q   <= FALSE;
            q1_q      <= '0;
            v1_q      <= '0;
            q2_q      <= '0;
            v2_q      <= '0;
            ena_rs_q  <= FALSE;
            ena_lsb_q <= FALSE;
            ena_rob_q <= FALSE;
            ena_reg_q <= FALSE;
            out_op_q  <= OPENUM_W'(OPENUM_NOP);
            out_pc_q  <= '0;
            out_imm_q <= '0;
            out_rd_q  <= '0;
            out_q1_q  <= '0;
            out_q2_q  <= '0;
            out_v1_q  <= '0;
            out_v2_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            is_ls_q   <= is_ls_d;
            q1_q      <= q1_d;
            v1_q      <= v1_d;
            q2_q      <= q2_d;
            v2_q      <= v2_d;
            ena_rs_q  <= ena_rs_d;
            ena_lsb_q <= ena_lsb_d;
            ena_rob_q <= ena_rob_d;
            ena_reg_q <= ena_reg_d;
            out_op_q  <= out_op_d;
            out_pc_q  <= out_pc_d;
            out_imm_q <= out_imm_d;
            out_rd_q  <= out_rd_d;
            out_q1_q  <= out_q1_d;
            out_q2_q  <= out_q2_d;
            out_v1_q  <= out_v1_d;
            out_v2_q  <= out_v2_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign ena_to_rs        = ena_rs_q;
    assign ena_to_lsb       = ena_lsb_q;
    assign ena_to_rob       = ena_rob_q;
    assign ena_to_reg       = ena_reg_q;
    assign openum_to_rs_lsb = out_op_q;
    assign V1_to_rs_lsb     = out_v1_q;
    assign V2_to_rs_lsb     = out_v2_q;
    assign Q1_to_rs_lsb     = out_q1_q;
    assign Q2_to_rs_lsb     = out_q2_q;
    assign pc_to_rs_lsb     = out_pc_q;
    assign imm_to_rs_lsb    = out_imm_q;
    assign rob_id_to_rs_lsb = out_tag_q;
    assign rd_to_rob        = out_rd_q;
    assign openum_to_rob    = out_op_q;
    assign pc_to_rob        = out_pc_q;
    assign rd_to_reg        = out_rd_q;
    assign rob_id_to_reg    = out_tag_q;

`ifdef DSP_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // counts frozen-decoder cycles; rollback does not clear it
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rdy && stall_to_dcd) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dispatcher.sv
// Directed and random checks of the dispatcher against a queue-based
// model of the skid slot and the registered dispatch outputs.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        valid_from_dcd;
    logic [5:0]  openum_from_dcd;
    logic [31:0] pc_from_dcd, imm_from_dcd;
    logic [4:0]  rd_from_dcd, rs1_from_dcd, rs2_from_dcd;
    logic        use_rs2_from_dcd, is_ls_from_dcd;
    logic        stall_to_dcd;
    logic [4:0]  rs1_to_reg, rs2_to_reg;
    logic [3:0]  Q1_from_reg, Q2_from_reg;
    logic [31:0] V1_from_reg, V2_from_reg;
    logic [3:0]  Q1_to_rob, Q2_to_rob;
    logic        ready1_from_rob, ready2_from_rob;
    logic [31:0] value1_from_rob, value2_from_rob;
    logic [3:0]  free_id_from_rob;
    logic        full_from_rob;
    logic        ena_to_rob;
    logic [4:0]  rd_to_rob;
    logic [5:0]  openum_to_rob;
    logic [31:0] pc_to_rob;
    logic        ena_to_reg;
    logic [4:0]  rd_to_reg;
    logic [3:0]  rob_id_to_reg;
    logic        full_from_rs, full_from_lsb;
    logic        ena_to_rs, ena_to_lsb;
    logic [5:0]  openum_to_rs_lsb;
    logic [31:0] V1_to_rs_lsb, V2_to_rs_lsb;
    logic [3:0]  Q1_to_rs_lsb, Q2_to_rs_lsb;
    logic [31:0] pc_to_rs_lsb, imm_to_rs_lsb;
    logic [3:0]  rob_id_to_rs_lsb;
    logic        valid_from_rs_cdb;
    logic [3:0]  rob_id_from_rs_cdb;
    logic [31:0] result_from_rs_cdb;
    logic        valid_from_ls_cdb;
    logic [3:0]  rob_id_from_ls_cdb;
    logic [31:0] result_from_ls_cdb;
    logic        rollback_flag_from_rob;
`ifdef DSP_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] e_cnt;
`endif

    dispatcher dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .valid_from_dcd(valid_from_dcd),
        .openum_from_dcd(openum_from_dcd),
        .pc_from_dcd(pc_from_dcd),
        .imm_from_dcd(imm_from_dcd),
        .rd_from_dcd(rd_from_dcd),
        .rs1_from_dcd(rs1_from_dcd),
        .rs2_from_dcd(rs2_from_dcd),
        .use_rs2_from_dcd(use_rs2_from_dcd),
        .is_ls_from_dcd(is_ls_from_dcd),
        .stall_to_dcd(stall_to_dcd),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
        .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
        .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
        .ready1_from_rob(ready1_from_rob),
        .ready2_from_rob(ready2_from_rob),
        .value1_from_rob(value1_from_rob),
        .value2_from_rob(value2_from_rob),
        .free_id_from_rob(free_id_from_rob),
        .full_from_rob(full_from_rob),
        .ena_to_rob(ena_to_rob), .rd_to_rob(rd_to_rob),
        .openum_to_rob(openum_to_rob), .pc_to_rob(pc_to_rob),
        .ena_to_reg(ena_to_reg), .rd_to_reg(rd_to_reg),
        .rob_id_to_reg(rob_id_to_reg),
        .full_from_rs(full_from_rs), .full_from_lsb(full_from_lsb),
        .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb),
        .openum_to_rs_lsb(openum_to_rs_lsb),
        .V1_to_rs_lsb(V1_to_rs_lsb), .V2_to_rs_lsb(V2_to_rs_lsb),
        .Q1_to_rs_lsb(Q1_to_rs_lsb), .Q2_to_rs_lsb(Q2_to_rs_lsb),
        .pc_to_rs_lsb(pc_to_rs_lsb), .imm_to_rs_lsb(imm_to_rs_lsb),
        .rob_id_to_rs_lsb(rob_id_to_rs_lsb),
        .valid_from_rs_cdb(valid_from_rs_cdb),
        .rob_id_from_rs_cdb(rob_id_from_rs_cdb),
        .result_from_rs_cdb(result_from_rs_cdb),
        .valid_from_ls_cdb(valid_from_ls_cdb),
        .rob_id_from_ls_cdb(rob_id_from_ls_cdb),
        .result_from_ls_cdb(result_from_ls_cdb),
        .rollback_flag_from_rob(rollback_flag_from_rob)
`ifdef DSP_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        is_ls;
        logic [3:0]  q1;
        logic [31:0] v1;
        logic [3:0]  q2;
        logic [31:0] v2;
    } insn_t;

    insn_t skid[$];
    insn_t e_out;
    logic [3:0] e_tag;
    logic e_rs, e_lsb, e_rob, e_reg, e_stall;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rs_hit(input logic [3:0] q);
        return valid_from_rs_cdb && q != 0 && rob_id_from_rs_cdb == q;
    endfunction

    function automatic logic ls_hit(input logic [3:0] q);
        return valid_from_ls_cdb && q != 0 && rob_id_from_ls_cdb == q;
    endfunction

    // where an operand's value comes from when the decoder hands it over
    task automatic resolve(input logic [4:0] rs, input logic used,
                           input logic [3:0] qr, input logic [31:0] vr,
                           input logic rr, input logic [31:0] rv,
                           output logic [3:0] q, output logic [31:0] v);
        q = 0;
        v = 0;
        if (used && rs != 0) begin
            if (qr == 0) v = vr;
            else if (rs_hit(qr)) v = result_from_rs_cdb;
            else if (ls_hit(qr)) v = result_from_ls_cdb;
            else if (rr) v = rv;
            else q = qr;
        end
    endtask

    task automatic snoop(inout logic [3:0] q, inout logic [31:0] v);
        if (rs_hit(q)) begin
            v = result_from_rs_cdb;
            q = 0;
        end else if (ls_hit(q)) begin
            v = result_from_ls_cdb;
            q = 0;
        end
    endtask

    task automatic model_reset();
        skid.delete();
        e_out = '{default: '0};
        e_tag = 0;
        e_rs = 0; e_lsb = 0; e_rob = 0; e_reg = 0;
`ifdef DSP_STALL_CNT_EN
        e_cnt = 0;
`endif
    endtask

    // one clock edge of the model, evaluated on the inputs now applied
    task automatic model_step();
        logic go;
        insn_t n;
        go = 0;
        e_rs = 0; e_lsb = 0; e_rob = 0; e_reg = 0;
        if (skid.size() != 0 && rdy && !rollback_flag_from_rob)
            go = !full_from_rob &&
                 !(skid[0].is_ls ? full_from_lsb : full_from_rs);
        e_stall = skid.size() != 0 && !go;
        chk("stall_to_dcd", stall_to_dcd, e_stall);
        chk("rs1_to_reg", rs1_to_reg, rs1_from_dcd);
        chk("Q2_to_rob", Q2_to_rob, Q2_from_reg);
`ifdef DSP_STALL_CNT_EN
        if (rdy && e_stall) e_cnt++;
`endif
        if (rollback_flag_from_rob) begin
            skid.delete();
        end else if (rdy) begin
            if (skid.size() != 0) begin
                n = skid[0];
                snoop(n.q1, n.v1);
                snoop(n.q2, n.v2);
                skid[0] = n;
            end
            if (go) begin
                e_out = skid.pop_front();
                e_tag = free_id_from_rob;
                e_rs  = !e_out.is_ls;
                e_lsb = e_out.is_ls;
                e_rob = 1;
                e_reg = e_out.rd != 0;
            end
            if (valid_from_dcd && skid.size() == 0) begin
                n.op = openum_from_dcd;
                n.pc = pc_from_dcd;
                n.imm = imm_from_dcd;
                n.rd = rd_from_dcd;
                n.is_ls = is_ls_from_dcd;
                resolve(rs1_from_dcd, 1'b1, Q1_from_reg, V1_from_reg,
                        ready1_from_rob, value1_from_rob, n.q1, n.v1);
                resolve(rs2_from_dcd, use_rs2_from_dcd, Q2_from_reg,
                        V2_from_reg, ready2_from_rob, value2_from_rob,
                        n.q2, n.v2);
                skid.push_back(n);
            end
        end
    endtask

    task automatic check_outputs();
        chk("ena_to_rs", ena_to_rs, e_rs);
        chk("ena_to_lsb", ena_to_lsb, e_lsb);
        chk("ena_to_rob", ena_to_rob, e_rob);
        chk("ena_to_reg", ena_to_reg, e_reg);
        chk("openum_to_rs_lsb", openum_to_rs_lsb, e_out.op);
        chk("V1_to_rs_lsb", V1_to_rs_lsb, e_out.v1);
        chk("V2_to_rs_lsb", V2_to_rs_lsb, e_out.v2);
        chk("Q1_to_rs_lsb", Q1_to_rs_lsb, e_out.q1);
        chk("Q2_to_rs_lsb", Q2_to_rs_lsb, e_out.q2);
        chk("pc_to_rs_lsb", pc_to_rs_lsb, e_out.pc);
        chk("imm_to_rs_lsb", imm_to_rs_lsb, e_out.imm);
        chk("rob_id_to_rs_lsb", rob_id_to_rs_lsb, e_tag);
        chk("rd_to_rob", rd_to_rob, e_out.rd);
        chk("openum_to_rob", openum_to_rob, e_out.op);
        chk("pc_to_rob", pc_to_rob, e_out.pc);
        chk("rd_to_reg", rd_to_reg, e_out.rd);
        chk("rob_id_to_reg", rob_id_to_reg, e_tag);
`ifdef DSP_STALL_CNT_EN
        chk("stall_cnt_o", stall_cnt, e_cnt);
`endif
    endtask

    // inputs are applied at a falling edge; check after the next one
    task automatic tick();
        #1;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        rdy = 1; valid_from_dcd = 0; openum_from_dcd = 0;
        pc_from_dcd = 0; imm_from_dcd = 0; rd_from_dcd = 0;
        rs1_from_dcd = 0; rs2_from_dcd = 0;
        use_rs2_from_dcd = 1; is_ls_from_dcd = 0;
        Q1_from_reg = 0; Q2_from_reg = 0;
        V1_from_reg = 0; V2_from_reg = 0;
        ready1_from_rob = 0; ready2_from_rob = 0;
        value1_from_rob = 0; value2_from_rob = 0;
        free_id_from_rob = 4'd1; full_from_rob = 0;
        full_from_rs = 0; full_from_lsb = 0;
        valid_from_rs_cdb = 0; rob_id_from_rs_cdb = 0;
        result_from_rs_cdb = 0;
        valid_from_ls_cdb = 0; rob_id_from_ls_cdb = 0;
        result_from_ls_cdb = 0;
        rollback_flag_from_rob = 0;
    endtask

    task automatic insn(input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ls, input logic [31:0] pc);
        valid_from_dcd = 1; openum_from_dcd = op;
        rd_from_dcd = rd; rs1_from_dcd = rs1; rs2_from_dcd = rs2;
        use_rs2_from_dcd = 1; is_ls_from_dcd = ls;
        pc_from_dcd = pc; imm_from_dcd = pc + 32'd4;
    endtask

    initial begin
        rst = 1;
        idle();
        model_reset();
        #12;
        check_outputs();
        chk("reset stall", stall_to_dcd, 1'b0);
        @(negedge clk);
        rst = 0;

        // add x3,x1,x2 with both operands ready in the regfile
        insn(6'd1, 5'd3, 5'd1, 5'd2, 1'b0, 32'h100);
        V1_from_reg = 5; V2_from_reg = 7; free_id_from_rob = 4'd5;
        tick();
        valid_from_dcd = 0;
        tick();
        chk("t1 ena_to_rs", ena_to_rs, 1'b1);
        chk("t1 V1", V1_to_rs_lsb, 32'd5);
        chk("t1 V2", V2_to_rs_lsb, 32'd7);
        chk("t1 Q1", Q1_to_rs_lsb, 4'd0);
        chk("t1 ena_to_reg", ena_to_reg, 1'b1);
        chk("t1 rd_to_reg", rd_to_reg, 5'd3);
        chk("t1 rob_id_to_reg", rob_id_to_reg, 4'd5);
        idle();
        tick();
        chk("t1 ena drops", ena_to_rs, 1'b0);

        // RS CDB resolves a pending tag in the capture cycle
        insn(6'd2, 5'd4, 5'd1, 5'd0, 1'b0, 32'h200);
        Q1_from_reg = 4; valid_from_rs_cdb = 1;
        rob_id_from_rs_cdb = 4; result_from_rs_cdb = 32'h10;
        tick();
        idle();
        tick();
        chk("t2 Q1", Q1_to_rs_lsb, 4'd0);
        chk("t2 V1", V1_to_rs_lsb, 32'h10);

        // stalled by a full RS while the LS CDB fills Q2
        insn(6'd3, 5'd5, 5'd1, 5'd6, 1'b0, 32'h300);
        Q2_from_reg = 2; full_from_rs = 1;
        tick();
        idle();
        full_from_rs = 1;
        tick();
        chk("t3 no ena", ena_to_rs, 1'b0);
        valid_from_ls_cdb = 1; rob_id_from_ls_cdb = 2;
        result_from_ls_cdb = 32'h22;
        tick();
        valid_from_ls_cdb = 0;
        tick();
        chk("t3 still no ena", ena_to_rs, 1'b0);
        full_from_rs = 0;
        tick();
        chk("t3 ena_to_rs", ena_to_rs, 1'b1);
        chk("t3 Q2", Q2_to_rs_lsb, 4'd0);
        chk("t3 V2", V2_to_rs_lsb, 32'h22);

        // load goes to the LSB although the RS is full
        idle();
        insn(6'd9, 5'd7, 5'd2, 5'd0, 1'b1, 32'h400);
        use_rs2_from_dcd = 0; full_from_rs = 1;
        tick();
        valid_from_dcd = 0;
        tick();
        chk("t4 ena_to_lsb", ena_to_lsb, 1'b1);
        chk("t4 ena_to_rs", ena_to_rs, 1'b0);

        // rollback empties the skid while it is blocked
        idle();
        insn(6'd4, 5'd8, 5'd1, 5'd2, 1'b0, 32'h500);
        full_from_rs = 1;
        tick();
        valid_from_dcd = 0; rollback_flag_from_rob = 1;
        tick();
        idle();
        tick();
        chk("t5 no ena", ena_to_rs, 1'b0);
        insn(6'd5, 5'd9, 5'd1, 5'd2, 1'b0, 32'h600);
        tick();
        idle();
        tick();
        chk("t5 ena after", ena_to_rs, 1'b1);
        chk("t5 pc", pc_to_rs_lsb, 32'h600);

        // rd=0 and rs1=0: no rename, operand 1 forced to zero
        insn(6'd6, 5'd0, 5'd0, 5'd2, 1'b0, 32'h700);
        Q1_from_reg = 3; V1_from_reg = 99;
        tick();
        idle();
        tick();
        chk("t6 ena_to_reg", ena_to_reg, 1'b0);
        chk("t6 V1", V1_to_rs_lsb, 32'd0);
        chk("t6 Q1", Q1_to_rs_lsb, 4'd0);

        // async reset while an instruction sits in the skid
        insn(6'd7, 5'd1, 5'd1, 5'd2, 1'b0, 32'h800);
        full_from_rs = 1;
        tick();
        valid_from_dcd = 0;
        #2;
        rst = 1;
        #1;
        chk("rst pc_to_rs_lsb", pc_to_rs_lsb, 32'd0);
        chk("rst stall", stall_to_dcd, 1'b0);
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 0;
        idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom % 8) != 0;
            rollback_flag_from_rob = ($urandom % 32) == 0;
            valid_from_dcd = ($urandom % 4) != 0;
            openum_from_dcd = 6'($urandom);
            pc_from_dcd = $urandom; imm_from_dcd = $urandom;
            rd_from_dcd = 5'($urandom % 8);
            rs1_from_dcd = 5'($urandom % 8);
            rs2_from_dcd = 5'($urandom % 8);
            use_rs2_from_dcd = 1'($urandom);
            is_ls_from_dcd = 1'($urandom);
            Q1_from_reg = 4'($urandom % 4);
            Q2_from_reg = 4'($urandom % 4);
            V1_from_reg = $urandom; V2_from_reg = $urandom;
            ready1_from_rob = ($urandom % 4) == 0;
            ready2_from_rob = ($urandom % 4) == 0;
            value1_from_rob = $urandom; value2_from_rob = $urandom;
            free_id_from_rob = 4'($urandom_range(1, 15));
            full_from_rob = ($urandom % 4) == 0;
            full_from_rs = ($urandom % 4) == 0;
            full_from_lsb = ($urandom % 4) == 0;
            valid_from_rs_cdb = 1'($urandom);
            rob_id_from_rs_cdb = 4'($urandom_range(1, 3));
            result_from_rs_cdb = $urandom;
            valid_from_ls_cdb = 1'($urandom);
            rob_id_from_ls_cdb = 4'($urandom_range(1, 3));
            result_from_ls_cdb = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
